// File: rtl/peripheral_msi_arbiter_qos_wb.sv
// rtl/peripheral_msi_arbiter_qos_wb.sv - Wishbone N:1 arbiter with round-robin/fixed QoS and stb watchdog
module peripheral_msi_arbiter_qos_wb #(
    parameter int NUM_MASTERS = 4,
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int ARB_MODE    = 0,
    parameter int TIMEOUT     = 64
) (
    input  logic                                 wb_clk_i,
    input  logic                                 wb_rst_i,
    input  logic [NUM_MASTERS-1:0][AW-1:0]       wbm_adr_i,
    input  logic [NUM_MASTERS-1:0][DW-1:0]       wbm_dat_i,
    input  logic [NUM_MASTERS-1:0][DW/8-1:0]     wbm_sel_i,
    input  logic [NUM_MASTERS-1:0]               wbm_we_i,
    input  logic [NUM_MASTERS-1:0]               wbm_cyc_i,
    input  logic [NUM_MASTERS-1:0]               wbm_stb_i,
    input  logic [NUM_MASTERS-1:0][2:0]          wbm_cti_i,
    input  logic [NUM_MASTERS-1:0][1:0]          wbm_bte_i,
    output logic [NUM_MASTERS-1:0][DW-1:0]       wbm_dat_o,
    output logic [NUM_MASTERS-1:0]               wbm_ack_o,
    output logic [NUM_MASTERS-1:0]               wbm_err_o,
    output logic [NUM_MASTERS-1:0]               wbm_rty_o,
    output logic [AW-1:0]                        wbs_adr_o,
    output logic [DW-1:0]                        wbs_dat_o,
    output logic [DW/8-1:0]                      wbs_sel_o,
    output logic                                 wbs_we_o,
    output logic                                 wbs_cyc_o,
    output logic                                 wbs_stb_o,
    output logic [2:0]                           wbs_cti_o,
    output logic [1:0]                           wbs_bte_o,
    input  logic [DW-1:0]                        wbs_dat_i,
    input  logic                                 wbs_ack_i,
    input  logic                                 wbs_err_i,
    input  logic                                 wbs_rty_i,
    output logic [NUM_MASTERS-1:0]               grant_o,
    output logic                                 timeout_o
);

    localparam int GW  = $clog2(NUM_MASTERS);
    // A zero TIMEOUT disables the watchdog; keep the counter one bit wide so it stays legal.
    localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t          state, state_nx;
    logic [GW-1:0]   g, g_nx, lg, lg_nx, winner, cand;
    logic [WDW-1:0]  wdc, wdc_nx;
    logic            busy, expire, found, any_resp;

    // Reset gates the bus combinationally so a reset cycle never forwards a slave response.
    assign busy     = (state == BUSY) & ~wb_rst_i;
    assign expire   = (TIMEOUT != 0) & busy & wbm_stb_i[g] & (wdc == WDW'(TIMEOUT));
    assign any_resp = wbs_ack_i | wbs_err_i | wbs_rty_i;

    assign wbs_cyc_o = busy & wbm_cyc_i[g] & ~expire;
    assign wbs_stb_o = wbs_cyc_o & wbm_stb_i[g];
    assign timeout_o = expire;
    assign wbm_dat_o = {NUM_MASTERS{wbs_dat_i}};

    // Winner selection: fixed priority favours the lowest index, round-robin searches from lg+1 with wrap.
    always_comb begin
        winner = '0;
        cand   = lg;
        found  = 1'b0;
        if (ARB_MODE == 1) begin
            for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
                if (wbm_cyc_i[i]) winner = GW'(i);
            end
        end else begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (cand == GW'(NUM_MASTERS - 1)) cand = '0;
                else                              cand = cand + GW'(1);
                if (!found && wbm_cyc_i[cand]) begin
                    winner = cand;
                    found  = 1'b1;
                end
            end
        end
    end

    // Route the granted master's request fields to the slave; everything is zero while idle.
    always_comb begin
        wbs_adr_o = '0;
        wbs_dat_o = '0;
        wbs_sel_o = '0;
        wbs_we_o  = 1'b0;
        wbs_cti_o = '0;
        wbs_bte_o = '0;
        if (busy) begin
            wbs_adr_o = wbm_adr_i[g];
            wbs_dat_o = wbm_dat_i[g];
            wbs_sel_o = wbm_sel_i[g];
            wbs_we_o  = wbm_we_i[g];
            wbs_cti_o = wbm_cti_i[g];
            wbs_bte_o = wbm_bte_i[g];
        end
    end

    // Responses reach only the granted master; an expiring watchdog turns the cycle into an error.
    always_comb begin
        grant_o   = '0;
        wbm_ack_o = '0;
        wbm_err_o = '0;
        wbm_rty_o = '0;
        if (busy) begin
            grant_o[g]   = 1'b1;
            wbm_ack_o[g] = wbs_ack_i & ~expire;
            wbm_rty_o[g] = wbs_rty_i & ~expire;
            wbm_err_o[g] = wbs_err_i | expire;
        end
    end

    // Next state: grant on any request from idle, hold the grant until the owner drops cyc.
    always_comb begin
        state_nx = state;
        g_nx     = g;
        lg_nx    = lg;
        case (state)
            IDLE: begin
                if (|wbm_cyc_i) begin
                    state_nx = BUSY;
                    g_nx     = winner;
                    lg_nx    = winner;
                end
            end
            BUSY: begin
                if (!wbm_cyc_i[g]) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Watchdog counts unanswered strobe cycles and restarts on any response, idle or expiry.
    always_comb begin
        wdc_nx = wdc;
        if (TIMEOUT == 0 || state != BUSY || expire || any_resp) wdc_nx = '0;
        else if (wbs_stb_o)                                      wdc_nx = wdc + WDW'(1);
    end

    // State, grant and watchdog registers.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
            g     <= '0;
            lg    <= GW'(NUM_MASTERS - 1);
            wdc   <= '0;
        end else begin
            state <= state_nx;
            g     <= g_nx;
            lg    <= lg_nx;
            wdc   <= wdc_nx;
        end
    end

endmodule

// File: tb/tb_peripheral_msi_arbiter_qos_wb.sv
// tb/tb_peripheral_msi_arbiter_qos_wb.sv - directed and random bench for the Wishbone QoS arbiter
module tb_peripheral_msi_arbiter_qos_wb;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        m_cyc [N];
    logic        m_stb [N];
    logic        m_we  [N];
    logic [31:0] m_adr [N];
    logic [31:0] m_dat [N];
    logic [3:0]  m_sel [N];
    logic [2:0]  m_cti [N];
    logic [1:0]  m_bte [N];
    logic        m_ack [N];
    logic        m_err [N];

    logic [N-1:0][31:0] p_adr, p_dat;
    logic [N-1:0][3:0]  p_sel;
    logic [N-1:0]       p_cyc, p_stb, p_we;
    logic [N-1:0][2:0]  p_cti;
    logic [N-1:0][1:0]  p_bte;

    logic        slave_en, s_err, s_rty, use_fp;

    logic [N-1:0][31:0] rr_mdat, fp_mdat;
    logic [N-1:0]       rr_ack, rr_err, rr_rty, rr_grant;
    logic [N-1:0]       fp_ack, fp_err, fp_rty, fp_grant;
    logic [31:0]        rr_sadr, rr_sdat, rr_sdat_i, fp_sadr, fp_sdat;
    logic [3:0]         rr_ssel, fp_ssel;
    logic               rr_swe, rr_scyc, rr_sstb, rr_to, rr_sack;
    logic               fp_swe, fp_scyc, fp_sstb, fp_to, fp_sack;
    logic [2:0]         rr_scti, fp_scti;
    logic [1:0]         rr_sbte, fp_sbte;

    logic        rr_ack_q, fp_ack_q;
    logic [31:0] mem     [256];
    logic [31:0] exp_mem [256];

    logic [N-1:0] cur_grant;
    logic [N-1:0] prev_grant = '0;
    int           direct_sw  = 0;
    int           multi      = 0;
    int           glog [$];

    always_comb begin
        p_adr = '0; p_dat = '0; p_sel = '0; p_cyc = '0;
        p_stb = '0; p_we  = '0; p_cti = '0; p_bte = '0;
        for (int i = 0; i < N; i++) begin
            p_adr[i] = m_adr[i]; p_dat[i] = m_dat[i]; p_sel[i] = m_sel[i];
            p_cyc[i] = m_cyc[i]; p_stb[i] = m_stb[i]; p_we[i]  = m_we[i];
            p_cti[i] = m_cti[i]; p_bte[i] = m_bte[i];
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            m_ack[i] = use_fp ? fp_ack[i] : rr_ack[i];
            m_err[i] = use_fp ? fp_err[i] : rr_err[i];
        end
        cur_grant = use_fp ? fp_grant : rr_grant;
    end

    peripheral_msi_arbiter_qos_wb #(.NUM_MASTERS(N), .AW(32), .DW(32), .ARB_MODE(0), .TIMEOUT(4)) dut_rr (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbm_adr_i(p_adr), .wbm_dat_i(p_dat), .wbm_sel_i(p_sel), .wbm_we_i(p_we),
        .wbm_cyc_i(p_cyc), .wbm_stb_i(p_stb), .wbm_cti_i(p_cti), .wbm_bte_i(p_bte),
        .wbm_dat_o(rr_mdat), .wbm_ack_o(rr_ack), .wbm_err_o(rr_err), .wbm_rty_o(rr_rty),
        .wbs_adr_o(rr_sadr), .wbs_dat_o(rr_sdat), .wbs_sel_o(rr_ssel), .wbs_we_o(rr_swe),
        .wbs_cyc_o(rr_scyc), .wbs_stb_o(rr_sstb), .wbs_cti_o(rr_scti), .wbs_bte_o(rr_sbte),
        .wbs_dat_i(rr_sdat_i), .wbs_ack_i(rr_sack), .wbs_err_i(s_err), .wbs_rty_i(s_rty),
        .grant_o(rr_grant), .timeout_o(rr_to)
    );

    peripheral_msi_arbiter_qos_wb #(.NUM_MASTERS(N), .AW(32), .DW(32), .ARB_MODE(1), .TIMEOUT(0)) dut_fp (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbm_adr_i(p_adr), .wbm_dat_i(p_dat), .wbm_sel_i(p_sel), .wbm_we_i(p_we),
        .wbm_cyc_i(p_cyc), .wbm_stb_i(p_stb), .wbm_cti_i(p_cti), .wbm_bte_i(p_bte),
        .wbm_dat_o(fp_mdat), .wbm_ack_o(fp_ack), .wbm_err_o(fp_err), .wbm_rty_o(fp_rty),
        .wbs_adr_o(fp_sadr), .wbs_dat_o(fp_sdat), .wbs_sel_o(fp_ssel), .wbs_we_o(fp_swe),
        .wbs_cyc_o(fp_scyc), .wbs_stb_o(fp_sstb), .wbs_cti_o(fp_scti), .wbs_bte_o(fp_sbte),
        .wbs_dat_i(32'h0), .wbs_ack_i(fp_sack), .wbs_err_i(1'b0), .wbs_rty_i(1'b0),
        .grant_o(fp_grant), .timeout_o(fp_to)
    );

    // Memory slave with one cycle ack latency behind the round-robin arbiter.
    always @(posedge clk) begin
        if (rst) begin
            rr_ack_q <= 1'b0;
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
        end else begin
            rr_ack_q <= rr_sstb & ~rr_ack_q & slave_en;
            if (rr_sstb & rr_swe & rr_ack_q) begin
                for (int b = 0; b < 4; b++)
                    if (rr_ssel[b]) mem[rr_sadr[9:2]][b*8 +: 8] <= rr_sdat[b*8 +: 8];
            end
        end
    end
    assign rr_sack   = rr_ack_q;
    assign rr_sdat_i = mem[rr_sadr[9:2]];

    // Ack-only slave behind the fixed-priority arbiter.
    always @(posedge clk) begin
        if (rst) fp_ack_q <= 1'b0;
        else     fp_ack_q <= fp_sstb & ~fp_ack_q & slave_en;
    end
    assign fp_sack = fp_ack_q;

    // Grant monitor: logs each new grant and counts multi-hot or back-to-back grant changes.
    always @(negedge clk) begin
        if (!rst) begin
            if (cur_grant != '0 && cur_grant != prev_grant) begin
                for (int i = 0; i < N; i++) if (cur_grant[i]) glog.push_back(i);
                if (prev_grant != '0) direct_sw <= direct_sw + 1;
            end
            if ($countones(cur_grant) > 1) multi <= multi + 1;
        end
        prev_grant <= cur_grant;
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drop_all();
        for (int i = 0; i < N; i++) begin
            m_cyc[i] = 1'b0; m_stb[i] = 1'b0; m_we[i] = 1'b0; m_cti[i] = 3'b000;
        end
    endtask

    // One master: n sequential single transactions, one idle cycle between them.
    task automatic master_run(input int m, input int n, input bit rnd);
        logic [7:0]  idx;
        logic [31:0] d;
        logic [3:0]  s;
        bit          w, done;
        int          cnt;
        for (int t = 0; t < n; t++) begin
            idx = rnd ? 8'(m * 64 + int'($urandom_range(0, 63))) : 8'(m * 64 + t);
            d   = rnd ? $urandom : (32'hC000_0000 | 32'(m << 8) | 32'(t));
            w   = rnd ? bit'($urandom_range(0, 1)) : 1'b1;
            s   = rnd ? 4'($urandom_range(1, 15)) : 4'hF;
            m_adr[m] = {22'h0, idx, 2'b00};
            m_dat[m] = d; m_we[m] = w; m_sel[m] = s;
            m_cyc[m] = 1'b1; m_stb[m] = 1'b1;
            done = 1'b0; cnt = 0;
            while (!done) begin
                @(negedge clk);
                cnt++;
                if (m_ack[m] || m_err[m]) done = 1'b1;
                else if (cnt > 400) begin
                    checks++; errors++;
                    $display("FAIL master_wait m=%0d: no ack within %0d cycles, required ack", m, cnt);
                    done = 1'b1;
                end
            end
            if (m_ack[m]) begin
                if (w) begin
                    for (int b = 0; b < 4; b++)
                        if (s[b]) exp_mem[idx][b*8 +: 8] = d[b*8 +: 8];
                end else begin
                    checks++;
                    if (rr_mdat[m] !== exp_mem[idx]) begin
                        errors++;
                        $display("FAIL read_data m=%0d idx=%0d: got %h required %h", m, idx, rr_mdat[m], exp_mem[idx]);
                    end
                end
            end
            @(negedge clk);
            m_cyc[m] = 1'b0; m_stb[m] = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < N; i++) begin m_cyc[i] = 1'b1; m_stb[i] = 1'b1; m_adr[i] = 32'hFFFF_FFFC; end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({rr_grant, fp_grant, rr_scyc, rr_sstb, rr_to} !== '0) begin
            errors++;
            $display("FAIL reset_grant: grant rr=%b fp=%b cyc=%b stb=%b to=%b required all 0", rr_grant, fp_grant, rr_scyc, rr_sstb, rr_to);
        end
        checks++;
        if ({rr_ack, rr_err, rr_rty, rr_sadr} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ack=%b err=%b rty=%b adr=%h required 0", rr_ack, rr_err, rr_rty, rr_sadr);
        end
        drop_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_master();
        do_reset();
        m_adr[2] = 32'h0000_0010; m_dat[2] = 32'hA5A5_1234; m_sel[2] = 4'hF; m_we[2] = 1'b1;
        m_cyc[2] = 1'b1; m_stb[2] = 1'b1;
        #1;
        checks++;
        if (rr_grant !== 4'b0000) begin errors++; $display("FAIL single_pre_grant: got %b required 0000", rr_grant); end
        @(negedge clk);
        checks++;
        if (rr_grant !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b required 0100", rr_grant); end
        checks++;
        if ({rr_scyc, rr_sstb, rr_swe, rr_sadr, rr_sdat, rr_ack} !== {3'b111, 32'h10, 32'hA5A5_1234, 4'b0000}) begin
            errors++;
            $display("FAIL single_route: cyc=%b stb=%b we=%b adr=%h dat=%h ack=%b", rr_scyc, rr_sstb, rr_swe, rr_sadr, rr_sdat, rr_ack);
        end
        @(negedge clk);
        checks++;
        if (rr_ack !== 4'b0100) begin errors++; $display("FAIL single_ack: got %b required 0100", rr_ack); end
        @(negedge clk);
        m_cyc[2] = 1'b0; m_stb[2] = 1'b0;
        #1;
        checks++;
        if ({rr_scyc, rr_grant} !== {1'b0, 4'b0100}) begin
            errors++; $display("FAIL single_release: cyc=%b grant=%b required 0 0100", rr_scyc, rr_grant);
        end
        @(negedge clk);
        checks++;
        if (rr_grant !== 4'b0000) begin errors++; $display("FAIL single_idle: got %b required 0000", rr_grant); end
        checks++;
        if (mem[4] !== 32'hA5A5_1234) begin errors++; $display("FAIL single_mem: got %h required a5a51234", mem[4]); end
        m_we[2] = 1'b0; m_cyc[2] = 1'b1; m_stb[2] = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({rr_ack, rr_mdat[0]} !== {4'b0100, 32'hA5A5_1234}) begin
            errors++; $display("FAIL single_read: ack=%b dat0=%h required 0100 a5a51234", rr_ack, rr_mdat[0]);
        end
        @(negedge clk);
        drop_all();
        @(negedge clk);
    endtask

    task automatic test_rty_err();
        do_reset();
        slave_en = 1'b0;
        m_adr[2] = 32'h0000_0020; m_we[2] = 1'b0; m_cyc[2] = 1'b1; m_stb[2] = 1'b1;
        @(negedge clk);
        s_rty = 1'b1;
        #1;
        checks++;
        if ({rr_rty, rr_err, rr_ack} !== {4'b0100, 4'b0000, 4'b0000}) begin
            errors++; $display("FAIL rty_route: rty=%b err=%b ack=%b required 0100 0000 0000", rr_rty, rr_err, rr_ack);
        end
        s_rty = 1'b0; s_err = 1'b1;
        #1;
        checks++;
        if ({rr_err, rr_rty} !== {4'b0100, 4'b0000}) begin
            errors++; $display("FAIL err_route: err=%b rty=%b required 0100 0000", rr_err, rr_rty);
        end
        s_err = 1'b0;
        drop_all();
        repeat (2) @(negedge clk);
        slave_en = 1'b1;
    endtask

    task automatic test_round_robin();
        int s0, d0;
        int exp_order [5];
        exp_order = '{0, 1, 2, 3, 0};
        do_reset();
        s0 = glog.size(); d0 = direct_sw;
        fork
            master_run(0, 2, 1'b0);
            master_run(1, 1, 1'b0);
            master_run(2, 1, 1'b0);
            master_run(3, 1, 1'b0);
        join
        repeat (2) @(negedge clk);
        checks++;
        if (glog.size() - s0 != 5) begin
            errors++; $display("FAIL rr_count: got %0d grants required 5", glog.size() - s0);
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (glog[s0 + k] != exp_order[k]) begin
                    errors++; $display("FAIL rr_order[%0d]: got %0d required %0d", k, glog[s0 + k], exp_order[k]);
                end
            end
        end
        checks++;
        if (direct_sw != d0) begin errors++; $display("FAIL rr_idle_gap: %0d grant changes without idle, required 0", direct_sw - d0); end
    endtask

    task automatic test_fixed_priority();
        int s0, n1, n3;
        do_reset();
        use_fp = 1'b1;
        s0 = glog.size();
        m_adr[3] = 32'h0000_0300; m_we[3] = 1'b0; m_cyc[3] = 1'b1; m_stb[3] = 1'b1;
        master_run(1, 4, 1'b0);
        m_cyc[3] = 1'b0; m_stb[3] = 1'b0;
        repeat (3) @(negedge clk);
        n1 = 0; n3 = 0;
        for (int k = s0; k < glog.size(); k++) begin
            if (glog[k] == 1) n1++;
            if (glog[k] == 3) n3++;
        end
        checks++;
        if (n1 != 4) begin errors++; $display("FAIL fp_master1: got %0d grants required 4", n1); end
        checks++;
        if (n3 != 0) begin errors++; $display("FAIL fp_master3_starved: got %0d grants required 0", n3); end
        use_fp = 1'b0;
    endtask

    task automatic test_timeout();
        int bad;
        do_reset();
        slave_en = 1'b0;
        m_adr[0] = 32'h0; m_we[0] = 1'b0; m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checks++;
            if ({rr_sstb, rr_err, rr_to} !== {1'b1, 4'b0000, 1'b0}) begin
                errors++; $display("FAIL wd_count[%0d]: stb=%b err=%b to=%b required 1 0000 0", k, rr_sstb, rr_err, rr_to);
            end
        end
        @(negedge clk);
        checks++;
        if ({rr_err, rr_to, rr_scyc, rr_sstb} !== {4'b0001, 1'b1, 1'b0, 1'b0}) begin
            errors++; $display("FAIL wd_expire: err=%b to=%b cyc=%b stb=%b required 0001 1 0 0", rr_err, rr_to, rr_scyc, rr_sstb);
        end
        @(negedge clk);
        checks++;
        if ({rr_err, rr_to, rr_sstb} !== {4'b0000, 1'b0, 1'b1}) begin
            errors++; $display("FAIL wd_restart: err=%b to=%b stb=%b required 0000 0 1", rr_err, rr_to, rr_sstb);
        end
        drop_all();
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (rr_err != 4'b0000 || rr_to) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL wd_after_release: %0d error cycles required 0", bad); end
        slave_en = 1'b1;
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        m_adr[1] = 32'h0000_0140; m_we[1] = 1'b0; m_cti[1] = 3'b010; m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
        @(negedge clk);
        checks++;
        if ({rr_grant, rr_scti} !== {4'b0010, 3'b010}) begin
            errors++; $display("FAIL burst_grant: grant=%b cti=%b required 0010 010", rr_grant, rr_scti);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({rr_scyc, rr_grant, rr_ack} !== {1'b0, 4'b0000, 4'b0000}) begin
            errors++; $display("FAIL burst_reset: cyc=%b grant=%b ack=%b required 0 0000 0000", rr_scyc, rr_grant, rr_ack);
        end
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[0] = 32'h0; m_we[0] = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (rr_grant !== 4'b0001) begin errors++; $display("FAIL burst_after_reset: grant=%b required 0001", rr_grant); end
        drop_all();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_random();
        int mm0, d0, bad;
        do_reset();
        for (int i = 0; i < 256; i++) exp_mem[i] = 32'h0;
        mm0 = multi; d0 = direct_sw;
        fork
            master_run(0, 40, 1'b1);
            master_run(1, 40, 1'b1);
            master_run(2, 40, 1'b1);
            master_run(3, 40, 1'b1);
        join
        repeat (2) @(negedge clk);
        checks++;
        if (multi != mm0) begin errors++; $display("FAIL rand_onehot: %0d multi-grant cycles required 0", multi - mm0); end
        checks++;
        if (direct_sw != d0) begin errors++; $display("FAIL rand_idle_gap: %0d direct switches required 0", direct_sw - d0); end
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== exp_mem[i]) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL rand_memory: %0d words differ required 0", bad); end
    endtask

    initial begin
        rst = 1'b1; slave_en = 1'b1; s_err = 1'b0; s_rty = 1'b0; use_fp = 1'b0;
        for (int i = 0; i < N; i++) begin
            m_adr[i] = '0; m_dat[i] = '0; m_sel[i] = 4'hF; m_bte[i] = '0;
        end
        drop_all();
        test_reset();
        test_single_master();
        test_rty_err();
        test_round_robin();
        test_fixed_priority();
        test_timeout();
        test_reset_mid_burst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule
